// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-RAM write/control outputs of the program loader.
// master = UART/testbench side, slave = loader.
interface instr_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  cpu_reset;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output rx_data, rx_valid,
    input  wr_en, wr_addr, wr_data, cpu_reset, busy, done, error
  );

  modport slave (
    input  rx_data, rx_valid,
    output wr_en, wr_addr, wr_data, cpu_reset, busy, done, error
  );
endinterface

// File: rtl/instr_loader.sv
// Assembles framed UART bytes into little-endian instruction words, writes them to
// instruction RAM and holds the CPU in reset until the frame checksum matches.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for SYNC_BYTE; other bytes ignored
// S_LEN_LO | expecting low byte of word count
// S_LEN_HI | expecting high byte of word count; range check
// S_DATA   | collecting 4 bytes per word, write after each 4th byte
// S_CSUM   | expecting XOR checksum of all data bytes
// S_DONE   | one-cycle success pulse, CPU released
// S_ERR    | one-cycle error entry, CPU stays held
module instr_loader #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          MEM_SIZE       = 512,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input logic            clk,
  input logic            reset,
  instr_loader_if.slave  bus
);

  localparam int IDX_W = $clog2(MEM_SIZE) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [15:0]      MAX_CNT = 16'(MEM_SIZE);
  localparam logic [TMO_W-1:0] TMO_TC  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t                r_state;
  logic [7:0]            r_len_lo;
  logic [15:0]           r_count;
  logic [IDX_W-1:0]      r_idx;
  logic [1:0]            r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_word;
  logic [7:0]            r_csum;
  logic [TMO_W-1:0]      r_tmo;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_cpu_reset;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic [15:0] w_len;
  logic [15:0] w_idx_next;
  logic        w_tmo_hit;

  assign w_len      = {bus.rx_data, r_len_lo};
  assign w_idx_next = 16'(r_idx) + 16'd1;
  assign w_tmo_hit  = !bus.rx_valid && (r_tmo == TMO_TC);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len_lo    <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_byte_cnt  <= '0;
      r_word      <= '0;
      r_csum      <= '0;
      r_tmo       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_cpu_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      if (bus.rx_valid || r_state == S_IDLE) r_tmo <= '0;
      else                                   r_tmo <= r_tmo + 1'b1;

      // Mid-frame silence aborts the frame from any collecting state.
      if (w_tmo_hit && (r_state == S_LEN_LO || r_state == S_LEN_HI ||
                        r_state == S_DATA   || r_state == S_CSUM)) begin
        r_state <= S_ERR;
        r_error <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
              r_state     <= S_LEN_LO;
              r_cpu_reset <= 1'b1;
              r_busy      <= 1'b1;
              r_error     <= 1'b0;
              r_csum      <= '0;
              r_idx       <= '0;
            end
          end
          S_LEN_LO: begin
            if (bus.rx_valid) begin
              r_len_lo <= bus.rx_data;
              r_state  <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            if (bus.rx_valid) begin
              r_count    <= w_len;
              r_byte_cnt <= '0;
              if (w_len > MAX_CNT) begin
                r_state <= S_ERR;
                r_error <= 1'b1;
                r_busy  <= 1'b0;
              end else if (w_len == 16'd0) begin
                r_state <= S_CSUM;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (bus.rx_valid) begin
              r_csum                          <= r_csum ^ bus.rx_data;
              r_word[{r_byte_cnt, 3'b000} +: 8] <= bus.rx_data;
              r_byte_cnt                      <= r_byte_cnt + 2'd1;
              if (r_byte_cnt == 2'd3) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= ADDR_WIDTH'(r_idx) << 2;
                r_wr_data <= {bus.rx_data, r_word[DATA_WIDTH-9:0]};
                r_idx     <= r_idx + 1'b1;
                if (w_idx_next == r_count) r_state <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            if (bus.rx_valid) begin
              r_busy <= 1'b0;
              if (bus.rx_data == r_csum) begin
                r_state     <= S_DONE;
                r_done      <= 1'b1;
                r_cpu_reset <= 1'b0;
              end else begin
                r_state <= S_ERR;
                r_error <= 1'b1;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          S_ERR:   r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.cpu_reset = r_cpu_reset;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;

endmodule

// File: tb/tb_instr_loader.sv
// Frame-level bench for instr_loader: directed frames plus random frames checked
// against a byte-list parser model of the frame format.
module tb_instr_loader;
  localparam int TMO = 16;

  typedef logic [7:0]  bq_t [$];
  typedef logic [63:0] wq_t [$];

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  instr_loader #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(512),
    .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int  n_checks = 0;
  int  n_pass   = 0;
  wq_t got_q;
  int  n_done   = 0;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) got_q.push_back({bus.wr_addr, bus.wr_data});
    if (bus.done === 1'b1) n_done++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // outc: 1 = done, 2 = error (bad length, bad checksum or truncated frame)
  function automatic void model(input bq_t f, output wq_t exp_q, output int outc);
    int cnt;
    logic [7:0]  cs;
    logic [31:0] w;
    exp_q = {};
    cs    = 8'h00;
    cnt   = int'(f[1]) + 256 * int'(f[2]);
    if (cnt > 512) begin outc = 2; return; end
    for (int k = 0; k < cnt; k++) begin
      if (3 + 4*k + 3 >= f.size()) begin outc = 2; return; end
      w = {f[3+4*k+3], f[3+4*k+2], f[3+4*k+1], f[3+4*k]};
      cs = cs ^ f[3+4*k] ^ f[3+4*k+1] ^ f[3+4*k+2] ^ f[3+4*k+3];
      exp_q.push_back({32'(k*4), w});
    end
    if (3 + 4*cnt >= f.size()) begin outc = 2; return; end
    outc = (f[3+4*cnt] == cs) ? 1 : 2;
  endfunction

  task automatic drive_frame(input bq_t f, input int max_gap);
    for (int i = 0; i < f.size(); i++) begin
      @(negedge clk);
      if (i == 1 && f[0] == 8'hA5) begin
        chk("cpu_reset_after_sync", {63'd0, bus.cpu_reset}, 64'd1);
        chk("busy_after_sync", {63'd0, bus.busy}, 64'd1);
        chk("error_cleared_by_sync", {63'd0, bus.error}, 64'd0);
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = f[i];
      repeat ($urandom_range(0, max_gap)) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bq_t f, input int max_gap, input bit truncated);
    wq_t exp_q;
    int  outc;
    int  w;
    int  n;
    model(f, exp_q, outc);
    got_q.delete();
    n_done = 0;
    drive_frame(f, max_gap);
    if (truncated) begin
      repeat (TMO - 1) @(negedge clk);
      chk({tag, "_no_early_timeout"}, {63'd0, bus.error}, 64'd0);
      @(negedge clk);
      chk({tag, "_timeout_error"}, {63'd0, bus.error}, 64'd1);
    end else begin
      w = 0;
      while (w < 40 && n_done == 0 && bus.error !== 1'b1) begin
        @(negedge clk);
        w++;
      end
    end
    repeat (2) @(negedge clk);
    chk({tag, "_n_writes"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i < 4 || i >= n - 2) chk({tag, "_write"}, got_q[i], exp_q[i]);
      else if (got_q[i] !== exp_q[i]) chk({tag, "_write"}, got_q[i], exp_q[i]);
    end
    chk({tag, "_done_pulses"}, 64'(n_done), (outc == 1) ? 64'd1 : 64'd0);
    chk({tag, "_error"}, {63'd0, bus.error}, (outc == 2) ? 64'd1 : 64'd0);
    chk({tag, "_cpu_reset"}, {63'd0, bus.cpu_reset}, (outc == 2) ? 64'd1 : 64'd0);
    chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
  endtask

  function automatic bq_t rand_frame();
    bq_t f;
    int  cnt;
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    if ($urandom_range(0, 9) == 0) cnt = $urandom_range(513, 1000);
    else                           cnt = $urandom_range(0, 6);
    f.push_back(8'hA5);
    f.push_back(cnt[7:0]);
    f.push_back(cnt[15:8]);
    if (cnt > 512) return f;
    for (int i = 0; i < 4*cnt; i++) begin
      b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
      cs ^= b;
      f.push_back(b);
    end
    if ($urandom_range(0, 3) == 0) cs ^= 8'($urandom_range(1, 255));
    f.push_back(cs);
    return f;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_wr_en"},     {63'd0, bus.wr_en},     64'd0);
    chk({tag, "_wr_addr"},   64'(bus.wr_addr),       64'd0);
    chk({tag, "_wr_data"},   64'(bus.wr_data),       64'd0);
    chk({tag, "_cpu_reset"}, {63'd0, bus.cpu_reset}, 64'd0);
    chk({tag, "_busy"},      {63'd0, bus.busy},      64'd0);
    chk({tag, "_done"},      {63'd0, bus.done},      64'd0);
    chk({tag, "_error"},     {63'd0, bus.error},     64'd0);
  endtask

  initial begin
    bq_t f;
    bq_t g;
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    f = '{8'hA5, 8'h02, 8'h00, 8'h17, 8'h01, 8'h00, 8'h02,
          8'h13, 8'h01, 8'h01, 8'h10, 8'h17};
    run_frame("good2", f, 0, 1'b0);
    f[11] = 8'h18;
    run_frame("badcsum", f, 1, 1'b0);
    run_frame("len513", '{8'hA5, 8'h01, 8'h02}, 0, 1'b0);
    run_frame("zero", '{8'hA5, 8'h00, 8'h00, 8'h00}, 0, 1'b0);
    run_frame("timeout", '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h01}, 0, 1'b1);
    f[11] = 8'h17;
    run_frame("retry", f, 2, 1'b0);

    // Reset mid-frame, then stray bytes must be ignored.
    got_q.delete();
    g = '{8'hA5, 8'h02, 8'h00, 8'h17, 8'h01, 8'h00};
    drive_frame(g, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("midreset");
    drive_frame('{8'h02, 8'h13, 8'h01, 8'h01, 8'h10, 8'h17}, 1);
    repeat (TMO + 4) @(negedge clk);
    chk("midreset_no_writes", 64'(got_q.size()), 64'd0);
    chk("midreset_busy", {63'd0, bus.busy}, 64'd0);
    chk("midreset_cpu_reset", {63'd0, bus.cpu_reset}, 64'd0);

    // Full-depth frame: count of exactly MEM_SIZE must not wrap.
    f = '{8'hA5, 8'h00, 8'h02};
    begin
      logic [7:0] cs;
      logic [7:0] b;
      cs = 8'h00;
      for (int i = 0; i < 4*512; i++) begin
        b = 8'($urandom);
        cs ^= b;
        f.push_back(b);
      end
      f.push_back(cs);
    end
    run_frame("full512", f, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      run_frame("rand", rand_frame(), 2, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Write-side counterpart of the single-cycle CPU's instruction memory.
- Receives a framed byte stream from the UART receiver and assembles little-endian 32-bit instruction words.
- Drives a write port into the instruction RAM.
- Holds the CPU in reset (reset2 net) while a program is being loaded, and releases it only after the frame checksum matches.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, byte-address width of the write port; same convention as instr_addr.
- MEM_SIZE, 512, instruction RAM depth in words.
- TIMEOUT_CYCLES, 100000, maximum idle clocks between bytes inside a frame.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
- wr_en  output  1  one-cycle instruction RAM write strobe.
- wr_addr  output  ADDR_WIDTH  byte address, always word aligned (index<<2).
- wr_data  output  DATA_WIDTH  assembled instruction word.
- cpu_reset  output  1  drives reset2 of the CPU/instruction memory; 1 = CPU held.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse on a successful load.
- error  output  1  sticky; set on a bad frame, cleared by the next SYNC_BYTE or by reset.

Behaviour:
- Reset (clk edge with reset=1): state IDLE; all outputs 0; word index, byte counter, checksum and timeout counter are 0. cpu_reset=0 so the program preloaded from hex runs. A reset mid-frame aborts the frame with no further writes.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then 4*LEN data bytes (LSB first per word), then CSUM. CSUM is the XOR of all data bytes only.
- IDLE: an rx_valid byte equal to SYNC_BYTE moves to LEN_LO and, on the same edge, sets cpu_reset=1, busy=1, error=0, checksum=0 and word index=0. Any other byte is ignored.
- LEN_LO: latch the low byte of the word count.
- LEN_HI: latch the high byte of the word count.
  - If count > MEM_SIZE, go to ERR.
  - If count == 0, go to CSUM.
  - Otherwise go to DATA.
- DATA: each byte shifts into the word register at position byte_cnt*8 and is XORed into the checksum.
  - On the 4th byte, the next clock presents wr_en=1 for exactly one cycle, with wr_addr=index<<2 and the complete word on wr_data. The index then increments.
  - After word count-1 is written, go to CSUM.
  - A byte arriving in the same cycle that wr_en is high is accepted normally; there is no back-pressure.
- CSUM:
  - Byte == checksum: go to DONE.
  - Byte != checksum: go to ERR.
- DONE: for one cycle done=1, cpu_reset=0 and busy=0, then return to IDLE. The CPU restarts from PC 0 because its reset is released.
- ERR: error=1, busy=0, cpu_reset stays 1 so a partial program never executes; return to IDLE. A new SYNC_BYTE starts a retry.
- Timeout: in any state other than IDLE, the counter resets on each rx_valid. When it reaches TIMEOUT_CYCLES-1 without a byte, go to ERR.
- A SYNC_BYTE value inside LEN/DATA/CSUM is treated as ordinary data, not as a restart.
- wr_addr and wr_data hold their last values when wr_en=0. Word index width is clog2(MEM_SIZE)+1, so a count of exactly MEM_SIZE does not wrap.

Test Plan:
- Send A5 02 00 17 01 00 02 13 01 01 10 17 -> expected response:
  - wr_en pulses at wr_addr 0x0 with data 0x02000117, then at 0x4 with data 0x10010113.
  - done pulses once; cpu_reset is 1 from the cycle after A5 and 0 after done; error stays 0.
- Same frame with the final byte 0x18 -> both writes occur, error=1, cpu_reset remains 1, done never pulses.
- Send A5 01 02 (count 513 > 512) -> error=1 immediately after LEN_HI; no wr_en.
- Send A5 00 00 00 -> zero-word frame: done pulses, no writes, cpu_reset returns to 0.
- Send A5 01 00 13 01 then stop for TIMEOUT_CYCLES (use 16 in sim) -> error=1, no wr_en. A following correct frame clears error and loads successfully.
- Assert reset for one cycle after the 6th byte of the first frame -> all outputs return to 0 the next cycle, no further writes, state IDLE; non-A5 bytes are then ignored.
